// File: rtl/dcache_direct.sv
// rtl/dcache_direct.sv - direct-mapped write-back write-allocate data cache, 8 lines x 4 words
// Optional perf counters (hit_cnt/miss_cnt) under `DCACHE_PERF_CNT_EN.
module dcache_direct (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt
`endif
);

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [7:0]   r_valid;
  logic [7:0]   r_dirty;
  logic [24:0]  r_tag  [8];
  logic [127:0] r_data [8];

  logic         w_req;
  logic [24:0]  w_tag;
  logic [2:0]   w_idx;
  logic [1:0]   w_off;
  logic         w_hit;
  logic [127:0] w_line;
  logic [6:0]   w_bit;

  assign w_req  = proc_read | proc_write;
  assign w_tag  = proc_addr[29:5];
  assign w_idx  = proc_addr[4:2];
  assign w_off  = proc_addr[1:0];
  assign w_line = r_data[w_idx];
  assign w_bit  = {w_off, 5'd0};
  assign w_hit  = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);

  // Array is reset to zero so the read mux never presents X.
  assign proc_rdata = w_line[w_bit +: 32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COMPARE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    proc_stall  = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = 28'd0;
    mem_wdata   = 128'd0;
    case (r_state)
      S_COMPARE: begin
        proc_stall = w_req & ~w_hit;
        if (w_req && !w_hit) begin
          if (r_valid[w_idx] && r_dirty[w_idx]) begin
            w_state_nxt = S_WRITEBACK;
          end else begin
            w_state_nxt = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {r_tag[w_idx], w_idx};
        mem_wdata = w_line;
        if (mem_ready) begin
          w_state_nxt = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = {w_tag, w_idx};
        if (mem_ready) begin
          w_state_nxt = S_COMPARE;
        end
      end
      default: begin
        w_state_nxt = S_COMPARE;
      end
    endcase
  end

  // Refill and write-hit never coincide: refill only happens outside COMPARE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 8'd0;
      r_dirty <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        r_tag[i]  <= 25'd0;
        r_data[i] <= 128'd0;
      end
    end else if (r_state == S_ALLOCATE && mem_ready) begin
      r_data[w_idx]  <= mem_rdata;
      r_tag[w_idx]   <= w_tag;
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (r_state == S_COMPARE && w_hit && proc_write) begin
      r_data[w_idx][w_bit +: 32] <= proc_wdata;
      r_dirty[w_idx]             <= 1'b1;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= 16'd0;
      r_miss_cnt <= 16'd0;
    end else if (r_state == S_COMPARE) begin
      if (w_hit && r_hit_cnt != 16'hFFFF) begin
        r_hit_cnt <= r_hit_cnt + 16'd1;
      end
      if (w_req && !w_hit && r_miss_cnt != 16'hFFFF) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/dcache_direct.md
# dcache_direct

Direct-mapped, write-back, write-allocate data cache between the MIPS core's data port and the off-chip slow data memory inside `CHIP`. It serves single-word (32-bit) core accesses from 8 lines of 4 words each. On a miss it writes back the dirty victim if needed, refills the 128-bit line, then lets the core proceed. Its core-facing write port is the same word-address/data/enable stream the testbench checker observes as `DCACHE_addr`/`DCACHE_wdata`/`DCACHE_wen`.

## Interface
- No parameters. Geometry is fixed: 8 lines × 128 bits; tag = `proc_addr[29:5]`, index = `proc_addr[4:2]`, word offset = `proc_addr[1:0]`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- `proc_read`  in  1  core word-read request.
- `proc_write`  in  1  core word-write request; takes priority if asserted together with `proc_read`.
- `proc_addr`  in  30  word address.
- `proc_wdata`  in  32  write data.
- `proc_rdata`  out  32  read data; valid in any cycle with `proc_read`=1 and `proc_stall`=0.
- `proc_stall`  out  1  core must hold its request while high.
- `mem_read`  out  1  line refill request to slow memory.
- `mem_write`  out  1  line write-back request to slow memory.
- `mem_addr`  out  28  line address (`addr[31:4]`).
- `mem_wdata`  out  128  write-back line data.
- `mem_rdata`  in  128  refill line data, valid when `mem_ready`=1.
- `mem_ready`  in  1  one-cycle completion pulse from slow memory.

## Operation
- Per-line state: `valid`, `dirty`, 25-bit tag, 128-bit data. Word w occupies bits `[32w+31:32w]`.
- Hit = request active ∧ `valid[idx]` ∧ `tag[idx]==proc_addr[29:5]`.
- FSM states: COMPARE (reset state), WRITEBACK, ALLOCATE.
- COMPARE, no request: `proc_stall`=0, stay.
- COMPARE, read hit: `proc_rdata` = addressed word, combinational from the array; `proc_stall`=0.
- COMPARE, write hit: `proc_stall`=0; at the edge, the word is replaced and `dirty[idx]`=1.
- COMPARE, miss: `proc_stall`=1. Next state is WRITEBACK if `valid∧dirty`, else ALLOCATE.
- WRITEBACK: `mem_write`=1, `mem_addr`={victim tag, idx}, `mem_wdata`=victim line, `proc_stall`=1. On `mem_ready`, go to ALLOCATE.
- ALLOCATE: `mem_read`=1, `mem_addr`={`proc_addr[29:5]`, idx}, `proc_stall`=1. On `mem_ready`, at the edge: line ← `mem_rdata`, tag updated, `valid`=1, `dirty`=0. Then go to COMPARE, where the access re-evaluates as a hit.
- `mem_read` and `mem_write` are decoded from the state register only, so they are glitch-free and never both high. They drop in the cycle after `mem_ready`.
- The core holds `proc_addr`/`proc_wdata` stable while stalled. The cache does not latch them.
- `proc_rdata` is don't-care when not reading. It must not be X after reset.

## Timing
- Reset (async assert): state=COMPARE, all `valid`/`dirty`=0, `mem_read`=`mem_write`=0, `proc_stall`=0 with no request, `mem_addr`=0, `mem_wdata`=0.
- Hit latency: 0 stall cycles.
- Clean miss: stall from cycle 0. `mem_read` is high from cycle 1 through the cycle of `mem_ready` (cycle 1+L). In cycle 2+L the state is COMPARE, the access hits and `proc_stall`=0. Total stall is L+2 cycles.
- Dirty miss: WRITEBACK for Lw+1 cycles, then ALLOCATE. Total stall is Lw+L+3 cycles.
- `mem_ready` outside WRITEBACK/ALLOCATE is ignored.
- Reset mid-miss: the FSM returns to COMPARE immediately, all lines become invalid, and the memory request drops asynchronously.
- Read and write to the same line on back-to-back hits: the write is visible to the next cycle's read.

## Configuration
- `DCACHE_PERF_CNT_EN` defined: adds outputs `hit_cnt` [15:0] and `miss_cnt` [15:0].
  - `hit_cnt` increments on each COMPARE-state hit with `proc_stall`=0. The re-evaluated hit after a refill also counts as a hit.
  - `miss_cnt` increments on each COMPARE→WRITEBACK/ALLOCATE transition.
  - Both saturate at 16'hFFFF and reset to 0.
- `DCACHE_PERF_CNT_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then read 30'h0 → `mem_read`=1, `mem_addr`=28'h0. Memory returns 128'h4444_4444_3333_3333_2222_2222_1111_1111 → `proc_rdata`=32'h1111_1111, stall lasts L+2 cycles.
- After the fill, read 30'h3 → 32'h4444_4444 with `proc_stall`=0 and no `mem_read`.
- Write 32'hDEAD_BEEF to 30'h1 (hit), then read 30'h1 → 32'hDEAD_BEEF, zero stall.
- Read 30'h20 (same index, new tag) → WRITEBACK first: `mem_addr`=28'h0, `mem_wdata[63:32]`=32'hDEAD_BEEF. Then ALLOCATE: `mem_addr`=28'h8.
- Assert `rst_n`=0 during ALLOCATE → `mem_read` falls immediately. Then read 30'h20 → treated as a clean miss, with no write-back.
- With `DCACHE_PERF_CNT_EN`, run the above sequence → counters equal the expected hit and miss counts (1 hit + 1 miss for the first read).
